bb_rz_frame_scheduler: RTL and testbench
========================================

# bb_rz_frame_scheduler

Frame-level scheduler that drives the RZ/FSK baseband pulse generator for bit '1'. It accepts bytes over a valid/ready stream and serializes each frame MSB-first onto the generator's bit input, one bit per RZ period. It prepends a fixed preamble and appends an inter-frame gap. It also restarts the generator's counters at every bit boundary and freezes the pulse-width configuration for the whole frame. It sits between the framing logic and the pulse generator in the transmit path.

## Interface
- BIT_PERIOD, 10, clock cycles per transmitted bit; equals the generator's RZ period (2..15)
- PREAMBLE_BITS, 8, preamble length in bits (1..8)
- PREAMBLE_PATTERN, 8'hAA, preamble bits, sent MSB-first from bit 7 downward
- GAP_BITS, 2, idle bit periods after each frame (1..15)

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cfg_pw1  in  2  pulse width 1 for the next frame
- cfg_pw2  in  2  pulse width 2 for the next frame
- in_data  in  8  byte to transmit
- in_valid  in  1  in_data/in_last valid
- in_last  in  1  byte is the last of its frame
- in_ready  out  1  scheduler accepts the byte this cycle
- bit_1  out  1  bit presented to the generator
- pw1  out  2  frame-latched pulse width 1
- pw2  out  2  frame-latched pulse width 2
- gen_rst  out  1  generator counter restart
- tx_active  out  1  frame in progress (PREAMBLE or DATA)
- frame_done  out  1  one-cycle pulse at end of gap
- underrun  out  1  one-cycle pulse when a frame is aborted for missing data

## Operation
- States: IDLE, PREAMBLE, DATA, GAP. Counters: per_cnt (0..BIT_PERIOD-1), bit_idx (0..7), gap_cnt.
- A handshake is in_valid && in_ready.
- IDLE: in_ready=1. On handshake:
  - latch the byte into the shift register and latch in_last;
  - latch cfg_pw1/cfg_pw2 into pw1/pw2;
  - go to PREAMBLE.
- PREAMBLE: shift out PREAMBLE_PATTERN[7] down to PREAMBLE_PATTERN[8-PREAMBLE_BITS]. Then go to DATA with bit_idx=7.
- DATA: shift out byte bits 7..0.
  - in_ready=1 only in the final cycle of bit 0 (per_cnt==BIT_PERIOD-1, bit_idx==0), and only if the latched in_last=0.
  - Handshake there: load the next byte; DATA continues with no idle cycle.
  - Latched in_last=1 at the end of bit 0: go to GAP.
  - No handshake when one was required: pulse underrun and go to GAP. The frame is aborted.
- GAP: bit_1=0 for GAP_BITS*BIT_PERIOD cycles. frame_done is high on the final gap cycle. Then go to IDLE.
- pw1/pw2 hold their values from frame start through the end of GAP. cfg_* changes mid-frame are ignored.
- bit_1 is registered and constant for a whole bit period.
- gen_rst is 1 in IDLE, 1 in GAP, and 1 on per_cnt==0 of every PREAMBLE/DATA bit. It is 0 otherwise.

## Timing
- Reset values: in_ready=0 in the reset cycle and 1 from the first IDLE cycle. bit_1=0, pw1=pw2=0, gen_rst=1, tx_active=0, frame_done=0, underrun=0. All counters are 0.
- Handshake in IDLE at cycle T:
  - first preamble bit and tx_active=1 at T+1;
  - first data bit at T+1+PREAMBLE_BITS*BIT_PERIOD.
- Frame of N bytes: (PREAMBLE_BITS+8N+GAP_BITS)*BIT_PERIOD cycles from T+1 until IDLE. IDLE is re-entered the cycle after frame_done.
- tx_active falls on the first GAP cycle.
- rst asserted in any state: IDLE with reset values on the next edge. The in-flight frame is dropped and no frame_done is issued.
- in_valid with in_ready=0 is held by the source. Nothing is consumed.

## Configuration
- BB_SCHED_PREAMBLE_EN defined: PREAMBLE state and the preamble parameters are compiled in, as described above.
- BB_SCHED_PREAMBLE_EN undefined:
  - PREAMBLE is removed; IDLE goes directly to DATA;
  - the first data bit is at T+1;
  - frame length is (8N+GAP_BITS)*BIT_PERIOD;
  - PREAMBLE_BITS and PREAMBLE_PATTERN are unused.

## Test plan
- Reset mid-frame: rst for 1 cycle during DATA bit 3 -> next cycle IDLE, gen_rst=1, bit_1=0, tx_active=0, in_ready=1. No frame_done.
- Single byte 8'hC5, in_last=1, defaults, macro defined:
  - bit_1 sequence is 1010_1010 then 1100_0101, 10 cycles per bit;
  - frame_done at T+180;
  - IDLE at T+181.
- Two bytes 8'h0F, 8'hF0 with cfg_pw1=2'd3, cfg_pw2=2'd1; cfg changed to 0 after acceptance:
  - second byte accepted in the last cycle of bit 0 of 8'h0F, with no gap between bytes;
  - pw1=3 and pw2=1 through GAP.
- Underrun: first byte 8'hFF with in_last=0, then in_valid=0 -> underrun pulse at the end of bit 0, 20 gap cycles with bit_1=0, frame_done, IDLE.
- gen_rst check: high exactly one cycle at each of the 16 bit starts of a 1-byte frame, low on the other 9 cycles of each bit.
- Macro undefined, byte 8'h80, in_last=1 -> bit_1=1 at T+1 for 10 cycles, then 0; frame_done at T+100.

Source files
------------

// File: rtl/bb_rz_frame_scheduler.sv
// ---------------------------------------------------------------------------
// bb_rz_frame_scheduler
//
// Frame-level scheduler in front of the RZ/FSK baseband pulse generator.
// Bytes arrive on a valid/ready stream and are sent MSB-first onto the
// generator's bit input, one bit per RZ period (BIT_PERIOD clocks). An
// optional fixed preamble goes before each frame. An idle gap of GAP_BITS
// bit periods follows each frame. The generator's counters are restarted
// at every bit boundary. The pulse-width configuration is frozen for the
// whole frame.
//
// Build option:
//   BB_SCHED_PREAMBLE_EN  - when defined, the PREAMBLE state and the
//                           PREAMBLE_BITS / PREAMBLE_PATTERN parameters are
//                           compiled in. When undefined, IDLE goes straight
//                           to DATA.
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous active-high reset
//   cfg_pw1    in   2  pulse width 1 for the next frame
//   cfg_pw2    in   2  pulse width 2 for the next frame
//   in_data    in   8  byte to transmit
//   in_valid   in   1  in_data/in_last valid
//   in_last    in   1  byte is the last of its frame
//   in_ready   out  1  scheduler accepts the byte this cycle
//   bit_1      out  1  registered bit presented to the generator
//   pw1        out  2  frame-latched pulse width 1
//   pw2        out  2  frame-latched pulse width 2
//   gen_rst    out  1  generator counter restart
//   tx_active  out  1  frame in progress (PREAMBLE or DATA)
//   frame_done out  1  one-cycle pulse on the final gap cycle
//   underrun   out  1  one-cycle pulse when a frame is aborted for lack of data
// ---------------------------------------------------------------------------
module bb_rz_frame_scheduler #(
   parameter int BIT_PERIOD = 10,
`ifdef BB_SCHED_PREAMBLE_EN
   parameter int PREAMBLE_BITS = 8,
   parameter logic [7:0] PREAMBLE_PATTERN = 8'hAA,
`endif
   parameter int GAP_BITS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] cfg_pw1,
   input  logic [1:0] cfg_pw2,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic       bit_1,
   output logic [1:0] pw1,
   output logic [1:0] pw2,
   output logic       gen_rst,
   output logic       tx_active,
   output logic       frame_done,
   output logic       underrun
);

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      GAP
   } state_t;

   localparam logic [3:0] PER_LAST = 4'(BIT_PERIOD - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_BITS * BIT_PERIOD - 1);

`ifdef BB_SCHED_PREAMBLE_EN
   localparam logic [2:0] PRE_LAST_IDX = 3'(8 - PREAMBLE_BITS);
   localparam state_t     FIRST_STATE  = PREAMBLE;
`else
   localparam state_t     FIRST_STATE  = DATA;
`endif

   state_t     state;
   state_t     next_state;
   logic [3:0] per_cnt;
   logic [2:0] bit_idx;
   logic [7:0] gap_cnt;
   logic [7:0] data_reg;
   logic       last_q;
   logic       bit_end;
   logic       gap_end;
   logic       accept;
   logic [2:0] idx_dn;

   assign bit_end = (per_cnt == PER_LAST);
   assign gap_end = (gap_cnt == GAP_LAST);
   assign idx_dn  = bit_idx - 3'd1;
   assign accept  = in_valid && in_ready;

   // State register; reset always lands in IDLE and drops any in-flight frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake/status outputs. The only mid-frame accept slot
   // is the final cycle of bit 0, so back-to-back bytes leave no idle cycle.
   // If nothing is offered there and the frame is not finished, the frame is
   // aborted into GAP. Reset masks all strobes, so an aborted frame never
   // reports frame_done or underrun.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      tx_active  = 1'b0;
      gen_rst    = 1'b0;
      frame_done = 1'b0;
      underrun   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            gen_rst  = 1'b1;
            if (in_valid) begin
               next_state = FIRST_STATE;
            end
         end
`ifdef BB_SCHED_PREAMBLE_EN
         PREAMBLE: begin
            tx_active = 1'b1;
            gen_rst   = (per_cnt == 4'd0);
            if (bit_end && bit_idx == PRE_LAST_IDX) begin
               next_state = DATA;
            end
         end
`endif
         DATA: begin
            tx_active = 1'b1;
            gen_rst   = (per_cnt == 4'd0);
            if (bit_end && bit_idx == 3'd0) begin
               if (last_q) begin
                  next_state = GAP;
               end else begin
                  in_ready = 1'b1;
                  if (!in_valid) begin
                     underrun   = 1'b1;
                     next_state = GAP;
                  end
               end
            end
         end
         GAP: begin
            gen_rst = 1'b1;
            if (gap_end) begin
               frame_done = 1'b1;
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (rst) begin
         in_ready   = 1'b0;
         frame_done = 1'b0;
         underrun   = 1'b0;
         next_state = IDLE;
      end
   end

   // Datapath: bit timing counters, byte holding register, and the registered
   // bit output. The next bit_1 value is loaded at each bit boundary, so the
   // output is constant for a full bit period. pw1/pw2 are loaded only when a
   // frame starts and keep their value until the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         per_cnt  <= 4'd0;
         bit_idx  <= 3'd0;
         gap_cnt  <= 8'd0;
         data_reg <= 8'd0;
         last_q   <= 1'b0;
         bit_1    <= 1'b0;
         pw1      <= 2'd0;
         pw2      <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  data_reg <= in_data;
                  last_q   <= in_last;
                  pw1      <= cfg_pw1;
                  pw2      <= cfg_pw2;
                  per_cnt  <= 4'd0;
                  bit_idx  <= 3'd7;
`ifdef BB_SCHED_PREAMBLE_EN
                  bit_1    <= PREAMBLE_PATTERN[7];
`else
                  bit_1    <= in_data[7];
`endif
               end
            end
`ifdef BB_SCHED_PREAMBLE_EN
            PREAMBLE: begin
               if (bit_end) begin
                  per_cnt <= 4'd0;
                  if (bit_idx == PRE_LAST_IDX) begin
                     bit_idx <= 3'd7;
                     bit_1   <= data_reg[7];
                  end else begin
                     bit_idx <= idx_dn;
                     bit_1   <= PREAMBLE_PATTERN[idx_dn];
                  end
               end else begin
                  per_cnt <= per_cnt + 4'd1;
               end
            end
`endif
            DATA: begin
               if (bit_end) begin
                  per_cnt <= 4'd0;
                  if (bit_idx != 3'd0) begin
                     bit_idx <= idx_dn;
                     bit_1   <= data_reg[idx_dn];
                  end else if (accept) begin
                     data_reg <= in_data;
                     last_q   <= in_last;
                     bit_idx  <= 3'd7;
                     bit_1    <= in_data[7];
                  end else begin
                     gap_cnt <= 8'd0;
                     bit_1   <= 1'b0;
                  end
               end else begin
                  per_cnt <= per_cnt + 4'd1;
               end
            end
            GAP: begin
               bit_1 <= 1'b0;
               if (gap_end) begin
                  gap_cnt <= 8'd0;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            default: begin
               per_cnt <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bb_rz_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bb_rz_frame_scheduler
//
// Self-checking bench for bb_rz_frame_scheduler. A behavioural model builds
// the expected bit stream of a frame from its bytes. It then derives the
// expected per-cycle outputs from bit and cycle positions. Directed frames
// come from a table, random frames from $urandom. Reset is checked by
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_bb_rz_frame_scheduler;

   localparam int BP  = 10;
   localparam int GAP = 2;
`ifdef BB_SCHED_PREAMBLE_EN
   localparam int         PRE = 8;
   localparam logic [7:0] PAT = 8'hAA;
`else
   localparam int         PRE = 0;
   localparam logic [7:0] PAT = 8'h00;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] cfg_pw1;
   logic [1:0] cfg_pw2;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic       bit_1;
   logic [1:0] pw1;
   logic [1:0] pw2;
   logic       gen_rst;
   logic       tx_active;
   logic       frame_done;
   logic       underrun;

   int check_count = 0;
   int error_count = 0;

   // Free-running clock, period 10 time units.
   always #5 clk = ~clk;

   bb_rz_frame_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_pw1    (cfg_pw1),
      .cfg_pw2    (cfg_pw2),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .bit_1      (bit_1),
      .pw1        (pw1),
      .pw2        (pw2),
      .gen_rst    (gen_rst),
      .tx_active  (tx_active),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   typedef struct {
      int              nb;
      logic [3:0][7:0] bytes;
      int              supply;
      logic [1:0]      p1;
      logic [1:0]      p2;
      int              exp_len;
      bit              exp_underrun;
   } vec_t;

   task automatic check_output(input string name, input int act, input int exp);
      check_count++;
      if (act !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One stream beat, driven 1 time unit after the rising edge.
   task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic l);
      @(posedge clk);
      #1;
      in_valid = v;
      in_data  = d;
      in_last  = l;
   endtask

   // Sends one frame and checks every cycle from T+1 to the first IDLE cycle
   // after it. The source offers supply of the nb bytes. If supply < nb, the
   // frame underruns. The source holds each byte until it is accepted.
   task automatic run_frame(input int nb, input logic [3:0][7:0] bytes,
                            input int supply, input logic [1:0] p1,
                            input logic [1:0] p2, input int idle_wait,
                            output int done_at, output bit saw_underrun);
      logic       exp_bits[$];
      logic [7:0] pat;
      int         sent, active, total, cur;
      logic       e_ready;
      pat      = PAT;
      sent     = (supply < nb) ? supply : nb;
      exp_bits = {};
      for (int i = 0; i < PRE; i++) exp_bits.push_back(pat[7-i]);
      for (int k = 0; k < sent; k++)
         for (int b = 7; b >= 0; b--) exp_bits.push_back(bytes[k][b]);
      active = (PRE + 8 * sent) * BP;
      total  = active + GAP * BP;

      for (int w = 0; w < idle_wait; w++) begin
         apply_stimulus(1'b0, 8'h00, 1'b0);
         @(negedge clk);
         check_output("idle_ready", int'(in_ready), 1);
      end
      cfg_pw1 = p1;
      cfg_pw2 = p2;
      apply_stimulus(1'b1, bytes[0], nb == 1);
      @(negedge clk);
      check_output("hs_ready", int'(in_ready), 1);

      cur          = 1;
      done_at      = -1;
      saw_underrun = 1'b0;
      for (int c = 0; c < total; c++) begin
         apply_stimulus(cur < supply, (cur < nb) ? bytes[cur] : 8'h00, cur == nb - 1);
         cfg_pw1 = ~p1;
         cfg_pw2 = ~p2;
         @(negedge clk);
         e_ready = 1'b0;
         for (int k = 0; k < sent; k++)
            if (k < nb - 1 && c == (PRE + 8 * (k + 1)) * BP - 1) e_ready = 1'b1;
         check_output("bit_1", int'(bit_1), (c < active) ? int'(exp_bits[c / BP]) : 0);
         check_output("gen_rst", int'(gen_rst), (c < active) ? int'(c % BP == 0) : 1);
         check_output("tx_active", int'(tx_active), int'(c < active));
         check_output("frame_done", int'(frame_done), int'(c == total - 1));
         check_output("underrun", int'(underrun), int'(sent < nb && c == active - 1));
         check_output("in_ready", int'(in_ready), int'(e_ready));
         check_output("pw1", int'(pw1), int'(p1));
         check_output("pw2", int'(pw2), int'(p2));
         if (frame_done) done_at = c;
         if (underrun) saw_underrun = 1'b1;
         if (in_valid && in_ready) cur++;
      end

      apply_stimulus(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      check_output("post_idle_active", int'(tx_active), 0);
      check_output("post_idle_genrst", int'(gen_rst), 1);
      check_output("post_idle_ready", int'(in_ready), 1);
      check_output("post_idle_bit", int'(bit_1), 0);
   endtask

   initial begin
      vec_t       vecs[5];
      int         done_at, nb, supply, rc;
      bit         saw_ur, saw_bad;
      logic [3:0][7:0] rb;

      vecs[0] = '{1, 32'h000000C5, 1, 2'd0, 2'd0, (PRE + 8 + GAP) * BP, 1'b0};
      vecs[1] = '{2, 32'h0000F00F, 2, 2'd3, 2'd1, (PRE + 16 + GAP) * BP, 1'b0};
      vecs[2] = '{2, 32'h000000FF, 1, 2'd2, 2'd2, (PRE + 8 + GAP) * BP, 1'b1};
      vecs[3] = '{1, 32'h00000080, 1, 2'd1, 2'd3, (PRE + 8 + GAP) * BP, 1'b0};
      vecs[4] = '{3, 32'h005AFF00, 3, 2'd2, 2'd1, (PRE + 24 + GAP) * BP, 1'b0};

      // Reset state, with a byte offered during reset that must not be taken.
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      in_last  = 1'b1;
      cfg_pw1  = 2'd3;
      cfg_pw2  = 2'd3;
      @(posedge clk);
      @(negedge clk);
      check_output("rst_ready", int'(in_ready), 0);
      check_output("rst_bit", int'(bit_1), 0);
      check_output("rst_pw1", int'(pw1), 0);
      check_output("rst_pw2", int'(pw2), 0);
      check_output("rst_genrst", int'(gen_rst), 1);
      check_output("rst_active", int'(tx_active), 0);
      check_output("rst_done", int'(frame_done), 0);
      check_output("rst_underrun", int'(underrun), 0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_output("first_idle_ready", int'(in_ready), 1);

      // Directed frames from the table.
      for (int i = 0; i < 5; i++) begin
         run_frame(vecs[i].nb, vecs[i].bytes, vecs[i].supply, vecs[i].p1,
                   vecs[i].p2, i % 3, done_at, saw_ur);
         check_output("tbl_frame_len", done_at + 1, vecs[i].exp_len);
         check_output("tbl_underrun", int'(saw_ur), int'(vecs[i].exp_underrun));
      end

      // Reset during DATA bit 3 of byte 8'h3C: the frame is dropped silently.
      cfg_pw1 = 2'd3;
      cfg_pw2 = 2'd2;
      apply_stimulus(1'b1, 8'h3C, 1'b0);
      @(negedge clk);
      check_output("mid_hs_ready", int'(in_ready), 1);
      rc = (PRE + 4) * BP + 2;
      for (int c = 0; c <= rc; c++) begin
         apply_stimulus(1'b0, 8'h00, 1'b0);
         if (c == rc) rst = 1'b1;
         @(negedge clk);
      end
      check_output("mid_bit3", int'(bit_1), 1);
      check_output("mid_active", int'(tx_active), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_output("mid_rst_active", int'(tx_active), 0);
      check_output("mid_rst_genrst", int'(gen_rst), 1);
      check_output("mid_rst_bit", int'(bit_1), 0);
      check_output("mid_rst_ready", int'(in_ready), 1);
      check_output("mid_rst_pw1", int'(pw1), 0);
      saw_bad = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (frame_done || tx_active || underrun) saw_bad = 1'b1;
      end
      check_output("mid_rst_no_done", int'(saw_bad), 0);

      // Random frames against the model.
      for (int r = 0; r < 12; r++) begin
         nb     = $urandom_range(1, 3);
         rb     = {$urandom, $urandom} ;
         supply = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb) : nb;
         run_frame(nb, rb, supply, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 3), done_at, saw_ur);
         check_output("rnd_frame_len", done_at + 1,
                      (PRE + 8 * ((supply < nb) ? supply : nb) + GAP) * BP);
         check_output("rnd_underrun", int'(saw_ur), int'(supply < nb));
      end

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
